// File: rtl/exe_mc.sv
// Execute / writeback stage with flush counter and an optional radix-2 multiplier.
// Macro EXE_MC_MUL_EN compiles the multiplier in. When it is not defined, a MUL
// instruction traps as an illegal instruction (cause 2).
module exe_mc #(
  parameter int XLEN        = 32,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dec_v_i,
  output logic            dec_rdy_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic            rd_v_i,
  input  logic [4:0]      rd_adr_i,
  input  logic [XLEN-1:0] res_data_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic            mul_v_i,
  input  logic            branch_v_i,
  input  logic [XLEN-1:0] branch_pc_i,
  input  logic            exc_v_i,
  input  logic [4:0]      exc_cause_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [XLEN-1:0] mtvec_i,
  output logic            wbk_v_q_o,
  output logic [4:0]      wbk_adr_q_o,
  output logic [XLEN-1:0] wbk_data_q_o,
  output logic            branch_v_q_o,
  output logic [XLEN-1:0] pc_data_q_o,
  output logic            exception_q_o,
  output logic [XLEN-1:0] mcause_q_o,
  output logic [XLEN-1:0] mepc_q_o,
  output logic            busy_o
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [2:0]      flush_q;
  logic            live;
  logic            exc_eff;
  logic [4:0]      cause_eff;
  logic            redirect;
  logic            alu_wr;
  logic            mul_wb;
  logic [4:0]      mul_wb_adr;
  logic [XLEN-1:0] mul_wb_data;
  logic            unused_bits;

  // Only instructions accepted with an empty flush window do anything.
  assign live     = dec_v_i & dec_rdy_o & (flush_q == 3'd0);
  assign redirect = live & (exc_eff | mret_i | branch_v_i);
  assign alu_wr   = live & rd_v_i & ~exc_eff & ~mul_v_i;

`ifdef EXE_MC_MUL_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] acc_q, mcand_q, mplier_q, acc_step;
  logic [4:0]      mul_rd_q;
  logic [CW-1:0]   cnt_q;
  logic            mul_start, mul_last;

  assign dec_rdy_o   = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign exc_eff     = exc_v_i;
  assign cause_eff   = exc_cause_i;
  assign mul_start   = live & mul_v_i & ~exc_v_i;
  assign mul_last    = (state_q == S_MUL) && (cnt_q == CW'(XLEN - 1));
  assign acc_step    = mplier_q[0] ? acc_q + mcand_q : acc_q;
  // Result is registered on the final step so the pulse is visible during DONE.
  assign mul_wb      = mul_last;
  assign mul_wb_adr  = mul_rd_q;
  assign mul_wb_data = acc_step;
  assign unused_bits = ^mtvec_i[1:0];

  // Multiplier state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: IDLE -> MUL on a live MUL, XLEN steps, one DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (mul_start) state_d = S_MUL;
      S_MUL:   if (mul_last)  state_d = S_DONE;
      S_DONE:                 state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Shift-add datapath: multiplicand shifts left, multiplier shifts right.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      mul_rd_q <= '0;
      cnt_q    <= '0;
    end else if (mul_start) begin
      acc_q    <= '0;
      mcand_q  <= rs1_data_i;
      mplier_q <= rs2_data_i;
      mul_rd_q <= rd_adr_i;
      cnt_q    <= '0;
    end else if (state_q == S_MUL) begin
      acc_q    <= acc_step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
  end
`else
  assign dec_rdy_o   = 1'b1;
  assign busy_o      = 1'b0;
  // MUL without the multiplier is an illegal instruction.
  assign exc_eff     = exc_v_i | mul_v_i;
  assign cause_eff   = exc_v_i ? exc_cause_i : 5'd2;
  assign mul_wb      = 1'b0;
  assign mul_wb_adr  = '0;
  assign mul_wb_data = '0;
  assign unused_bits = ^{mtvec_i[1:0], rs1_data_i, rs2_data_i};
`endif

  // Flush window: loaded on redirect, counts down and saturates at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                flush_q <= 3'd0;
    else if (redirect)        flush_q <= 3'(FLUSH_DEPTH);
    else if (flush_q != 3'd0) flush_q <= flush_q - 3'd1;
  end

  // Registered writeback / redirect / trap outputs; valids are single-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbk_v_q_o     <= 1'b0;
      wbk_adr_q_o   <= '0;
      wbk_data_q_o  <= '0;
      branch_v_q_o  <= 1'b0;
      pc_data_q_o   <= '0;
      exception_q_o <= 1'b0;
      mcause_q_o    <= '0;
      mepc_q_o      <= '0;
    end else begin
      wbk_v_q_o     <= 1'b0;
      branch_v_q_o  <= 1'b0;
      exception_q_o <= 1'b0;
      if (mul_wb) begin
        wbk_v_q_o    <= 1'b1;
        wbk_adr_q_o  <= mul_wb_adr;
        wbk_data_q_o <= mul_wb_data;
      end else if (alu_wr) begin
        wbk_v_q_o    <= 1'b1;
        wbk_adr_q_o  <= rd_adr_i;
        wbk_data_q_o <= res_data_i;
      end
      if (live & exc_eff) begin
        branch_v_q_o  <= 1'b1;
        exception_q_o <= 1'b1;
        pc_data_q_o   <= {mtvec_i[XLEN-1:2], 2'b00};
        mcause_q_o    <= {{(XLEN-5){1'b0}}, cause_eff};
        mepc_q_o      <= pc_i;
      end else if (live & mret_i) begin
        branch_v_q_o  <= 1'b1;
        pc_data_q_o   <= mepc_i;
      end else if (live & branch_v_i) begin
        branch_v_q_o  <= 1'b1;
        pc_data_q_o   <= branch_pc_i;
      end
    end
  end

endmodule

// File: tb/tb_exe_mc.sv
// Self-checking bench for exe_mc: directed table, corner sequences, and a
// randomized run against a transaction-level reference model.
module tb_exe_mc;
  localparam int XLEN = 32;
  localparam int FD   = 2;
`ifdef EXE_MC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            dec_v_i, dec_rdy_o, rd_v_i, mul_v_i, branch_v_i, exc_v_i, mret_i;
  logic [4:0]      rd_adr_i, exc_cause_i, wbk_adr_q_o;
  logic [XLEN-1:0] pc_i, res_data_i, rs1_data_i, rs2_data_i, branch_pc_i, mepc_i, mtvec_i;
  logic            wbk_v_q_o, branch_v_q_o, exception_q_o, busy_o;
  logic [XLEN-1:0] wbk_data_q_o, pc_data_q_o, mcause_q_o, mepc_q_o;

  exe_mc #(.XLEN(XLEN), .FLUSH_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .dec_v_i(dec_v_i), .dec_rdy_o(dec_rdy_o), .pc_i(pc_i),
    .rd_v_i(rd_v_i), .rd_adr_i(rd_adr_i), .res_data_i(res_data_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .mul_v_i(mul_v_i),
    .branch_v_i(branch_v_i), .branch_pc_i(branch_pc_i), .exc_v_i(exc_v_i),
    .exc_cause_i(exc_cause_i), .mret_i(mret_i), .mepc_i(mepc_i), .mtvec_i(mtvec_i),
    .wbk_v_q_o(wbk_v_q_o), .wbk_adr_q_o(wbk_adr_q_o), .wbk_data_q_o(wbk_data_q_o),
    .branch_v_q_o(branch_v_q_o), .pc_data_q_o(pc_data_q_o), .exception_q_o(exception_q_o),
    .mcause_q_o(mcause_q_o), .mepc_q_o(mepc_q_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_in();
    dec_v_i = 0; rd_v_i = 0; rd_adr_i = 0; res_data_i = 0; rs1_data_i = 0; rs2_data_i = 0;
    mul_v_i = 0; branch_v_i = 0; branch_pc_i = 0; exc_v_i = 0; exc_cause_i = 0;
    mret_i = 0; mepc_i = 0; mtvec_i = 0; pc_i = 0;
  endtask

  // Directed single-instruction vectors.
  typedef struct {
    logic rd_v; logic [4:0] rd; logic [31:0] res;
    logic exc_v; logic [4:0] cause; logic mret; logic br_v;
    logic [31:0] bpc, pc, mtvec, mepc;
    logic e_wbk; logic [4:0] e_adr; logic [31:0] e_data;
    logic e_br; logic [31:0] e_pc; logic e_exc; logic [31:0] e_mcause, e_mepc;
  } vec_t;
  vec_t vt[5];

  // Reference model state: counts of cycles, not RTL states.
  int          m_flush, m_busy;
  logic [31:0] m_prod;
  logic [4:0]  m_rd;
  logic        m_rdy;
  logic        e_wbk, e_br, e_exc;
  logic [4:0]  e_adr;
  logic [31:0] e_data, e_pc, e_mcause, e_mepc;

  task automatic m_reset();
    m_flush = 0; m_busy = 0; m_prod = 0; m_rd = 0; m_rdy = 1;
    e_wbk = 0; e_br = 0; e_exc = 0; e_adr = 0; e_data = 0; e_pc = 0; e_mcause = 0; e_mepc = 0;
  endtask

  // Predict the outputs after the next clock edge from the inputs now applied.
  task automatic m_step();
    bit live, is_exc, redir;
    live   = dec_v_i && m_rdy && (m_flush == 0);
    is_exc = exc_v_i || (!MUL_EN && mul_v_i);
    redir  = 0;
    e_wbk = 0; e_br = 0; e_exc = 0;
    if (m_busy > 0) m_busy--;
    if (m_busy == 1) begin e_wbk = 1; e_adr = m_rd; e_data = m_prod; end
    if (live) begin
      if (is_exc) begin
        e_exc = 1; e_br = 1; redir = 1;
        e_pc = mtvec_i & ~32'h3;
        e_mcause = exc_v_i ? {27'd0, exc_cause_i} : 32'd2;
        e_mepc = pc_i;
      end else if (mret_i) begin
        e_br = 1; redir = 1; e_pc = mepc_i;
      end else if (branch_v_i) begin
        e_br = 1; redir = 1; e_pc = branch_pc_i;
      end
      if (!is_exc && !mul_v_i && rd_v_i) begin
        e_wbk = 1; e_adr = rd_adr_i; e_data = res_data_i;
      end
      if (MUL_EN && mul_v_i && !exc_v_i) begin
        m_busy = XLEN + 1; m_prod = rs1_data_i * rs2_data_i; m_rd = rd_adr_i;
      end
    end
    m_flush = redir ? FD : (m_flush > 0 ? m_flush - 1 : 0);
    m_rdy = (m_busy == 0);
  endtask

  task automatic m_compare();
    chk("rnd_wbk_v", wbk_v_q_o, e_wbk);
    if (e_wbk) begin
      chk("rnd_wbk_adr", wbk_adr_q_o, e_adr);
      chk("rnd_wbk_data", wbk_data_q_o, e_data);
    end
    chk("rnd_br_v", branch_v_q_o, e_br);
    chk("rnd_exc", exception_q_o, e_exc);
    chk("rnd_pc", pc_data_q_o, e_pc);
    chk("rnd_mcause", mcause_q_o, e_mcause);
    chk("rnd_mepc", mepc_q_o, e_mepc);
    chk("rnd_rdy", dec_rdy_o, m_rdy);
    chk("rnd_busy", busy_o, !m_rdy);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    vt[0] = '{1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h10, 32'h0, 32'h0,
              1'b1, 5'd5, 32'h1234, 1'b0, 32'h0, 1'b0, 32'd0, 32'h0};
    vt[1] = '{1'b1, 5'd7, 32'h55, 1'b1, 5'd2, 1'b0, 1'b1, 32'h999, 32'h40, 32'h203, 32'h0,
              1'b0, 5'd0, 32'h0, 1'b1, 32'h200, 1'b1, 32'd2, 32'h40};
    vt[2] = '{1'b1, 5'd3, 32'hAA, 1'b0, 5'd0, 1'b1, 1'b0, 32'h0, 32'h50, 32'h0, 32'h300,
              1'b1, 5'd3, 32'hAA, 1'b1, 32'h300, 1'b0, 32'd2, 32'h40};
    vt[3] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h100, 32'h60, 32'h0, 32'h0,
              1'b0, 5'd0, 32'h0, 1'b1, 32'h100, 1'b0, 32'd2, 32'h40};
    vt[4] = '{1'b1, 5'd4, 32'h77, 1'b1, 5'd5, 1'b1, 1'b1, 32'h888, 32'h70, 32'h1000, 32'h300,
              1'b0, 5'd0, 32'h0, 1'b1, 32'h1000, 1'b1, 32'd5, 32'h70};

    idle_in();
    reset = 1;
    @(negedge clk); @(negedge clk);
    chk("rst_wbk_v", wbk_v_q_o, 0);   chk("rst_wbk_adr", wbk_adr_q_o, 0);
    chk("rst_wbk_data", wbk_data_q_o, 0); chk("rst_br_v", branch_v_q_o, 0);
    chk("rst_pc", pc_data_q_o, 0);    chk("rst_exc", exception_q_o, 0);
    chk("rst_mcause", mcause_q_o, 0); chk("rst_mepc", mepc_q_o, 0);
    chk("rst_busy", busy_o, 0);       chk("rst_rdy", dec_rdy_o, 1);
    reset = 0;
    tick();

    // Directed table.
    for (int i = 0; i < 5; i++) begin
      dec_v_i = 1; rd_v_i = vt[i].rd_v; rd_adr_i = vt[i].rd; res_data_i = vt[i].res;
      exc_v_i = vt[i].exc_v; exc_cause_i = vt[i].cause; mret_i = vt[i].mret;
      branch_v_i = vt[i].br_v; branch_pc_i = vt[i].bpc; pc_i = vt[i].pc;
      mtvec_i = vt[i].mtvec; mepc_i = vt[i].mepc;
      tick();
      idle_in();
      chk($sformatf("v%0d_wbk_v", i), wbk_v_q_o, vt[i].e_wbk);
      if (vt[i].e_wbk) begin
        chk($sformatf("v%0d_wbk_adr", i), wbk_adr_q_o, vt[i].e_adr);
        chk($sformatf("v%0d_wbk_data", i), wbk_data_q_o, vt[i].e_data);
      end
      chk($sformatf("v%0d_br_v", i), branch_v_q_o, vt[i].e_br);
      chk($sformatf("v%0d_pc", i), pc_data_q_o, vt[i].e_pc);
      chk($sformatf("v%0d_exc", i), exception_q_o, vt[i].e_exc);
      chk($sformatf("v%0d_mcause", i), mcause_q_o, vt[i].e_mcause);
      chk($sformatf("v%0d_mepc", i), mepc_q_o, vt[i].e_mepc);
      tick();
      chk($sformatf("v%0d_pulse_end", i), {wbk_v_q_o, branch_v_q_o, exception_q_o}, 0);
      tick(); tick();
    end

    // Branch followed by back-to-back instructions: two squashed, third writes.
    dec_v_i = 1; branch_v_i = 1; branch_pc_i = 32'h100; pc_i = 32'h200;
    tick();
    idle_in(); dec_v_i = 1; rd_v_i = 1; rd_adr_i = 1; res_data_i = 32'h11;
    chk("fl_br_v", branch_v_q_o, 1); chk("fl_pc", pc_data_q_o, 32'h100);
    tick();
    rd_adr_i = 2; res_data_i = 32'h22;
    chk("fl_sq1_rdy", dec_rdy_o, 1); chk("fl_sq1_wbk", wbk_v_q_o, 0);
    tick();
    rd_adr_i = 3; res_data_i = 32'h33;
    chk("fl_sq2_wbk", wbk_v_q_o, 0); chk("fl_sq2_br", branch_v_q_o, 0);
    tick();
    idle_in();
    chk("fl_live_wbk", wbk_v_q_o, 1); chk("fl_live_adr", wbk_adr_q_o, 3);
    chk("fl_live_data", wbk_data_q_o, 32'h33);
    tick(); tick();

`ifdef EXE_MC_MUL_EN
    // MUL 7 * -3, with a second MUL held behind it.
    dec_v_i = 1; mul_v_i = 1; rs1_data_i = 7; rs2_data_i = 32'hFFFFFFFD; rd_adr_i = 9; rd_v_i = 1;
    tick();
    rs1_data_i = 3; rs2_data_i = 5; rd_adr_i = 10;
    for (int k = 1; k <= 33; k++) begin
      chk($sformatf("mul1_rdy_c%0d", k), dec_rdy_o, 0);
      chk($sformatf("mul1_wbk_c%0d", k), wbk_v_q_o, k == 33);
      if (k == 33) begin
        chk("mul1_data", wbk_data_q_o, 32'hFFFFFFEB); chk("mul1_adr", wbk_adr_q_o, 9);
      end
      tick();
    end
    chk("mul2_rdy", dec_rdy_o, 1);
    tick();
    idle_in();
    seen = 0;
    for (int k = 1; k < 33; k++) begin
      if (wbk_v_q_o) seen = 1;
      tick();
    end
    chk("mul2_early_wbk", seen, 0);
    chk("mul2_wbk", wbk_v_q_o, 1); chk("mul2_data", wbk_data_q_o, 15);
    chk("mul2_adr", wbk_adr_q_o, 10);
    tick();
    // Reset during the multiply.
    dec_v_i = 1; mul_v_i = 1; rs1_data_i = 32'hFFFF; rs2_data_i = 32'hFFFF; rd_adr_i = 11;
    tick();
    idle_in();
    for (int k = 0; k < 10; k++) tick();
    chk("mrst_busy_before", busy_o, 1);
    reset = 1;
    #1;
    chk("mrst_busy", busy_o, 0);
    tick();
    reset = 0;
    chk("mrst_rdy", dec_rdy_o, 1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (wbk_v_q_o) seen = 1;
      tick();
    end
    chk("mrst_nowbk", seen, 0);
`else
    // MUL without a multiplier traps as illegal instruction.
    dec_v_i = 1; mul_v_i = 1; pc_i = 32'h80; rd_v_i = 1; rd_adr_i = 9; res_data_i = 5;
    rs1_data_i = 7; rs2_data_i = 3; mtvec_i = 32'h400;
    tick();
    idle_in();
    chk("ill_exc", exception_q_o, 1); chk("ill_mcause", mcause_q_o, 2);
    chk("ill_mepc", mepc_q_o, 32'h80); chk("ill_pc", pc_data_q_o, 32'h400);
    chk("ill_br", branch_v_q_o, 1);   chk("ill_wbk", wbk_v_q_o, 0);
    chk("ill_busy", busy_o, 0);       chk("ill_rdy", dec_rdy_o, 1);
    tick(); tick(); tick();
`endif

    // Randomized run against the reference model.
    reset = 1;
    tick();
    reset = 0;
    m_reset();
    for (int n = 0; n < 800; n++) begin
      dec_v_i = ($urandom % 4) != 0;
      rd_v_i = $urandom % 2; rd_adr_i = 5'($urandom); res_data_i = $urandom;
      exc_v_i = ($urandom % 8) == 0; exc_cause_i = 5'($urandom);
      mret_i = ($urandom % 10) == 0; branch_v_i = ($urandom % 4) == 0;
      branch_pc_i = $urandom; pc_i = $urandom; mtvec_i = $urandom; mepc_i = $urandom;
      mul_v_i = ($urandom % 8) == 0;
      rs1_data_i = $urandom; rs2_data_i = $urandom;
      if (mul_v_i) begin branch_v_i = 0; mret_i = 0; end
      m_step();
      tick();
      m_compare();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
